// File: rtl/seq_det_pkg.sv
// Shared constants and types for the programmable serial pattern detector.
// Defaults reproduce the fixed 1001/1111 Moore detector.
package seq_det_pkg;

    localparam int SEQ_LEN   = 4;
    localparam int SEQ_NPAT  = 2;
    localparam int SEQ_CNT_W = 8;

    localparam logic [SEQ_NPAT*SEQ_LEN-1:0] SEQ_PAT_INIT = {4'b1111, 4'b1001};

    typedef enum logic {
        SEQ_NONOVL = 1'b0,
        SEQ_OVL    = 1'b1
    } seq_mode_t;

endpackage

// File: rtl/seq_pattern_bank.sv
// Runtime-programmable pattern registers with one comparator per pattern.
// Comparison uses the registered pattern, so a same-edge load applies next sample.
module seq_pattern_bank
    import seq_det_pkg::*;
#(
    parameter int LEN   = SEQ_LEN,
    parameter int NPAT  = SEQ_NPAT,
    parameter int SEL_W = 1,
    parameter logic [NPAT*LEN-1:0] PAT_INIT = (NPAT*LEN)'(SEQ_PAT_INIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pat_load,
    input  logic [SEL_W-1:0] pat_sel,
    input  logic [LEN-1:0]   pat_data,
    input  logic [LEN-1:0]   nh,
    input  logic             full,
    output logic [NPAT-1:0]  m
);

    logic [NPAT-1:0][LEN-1:0] pat_q;
    logic [NPAT-1:0][LEN-1:0] pat_d;

    // Out-of-range selects match no index and are dropped.
    always_comb begin
        pat_d = pat_q;
        for (int i = 0; i < NPAT; i++) begin
            if (pat_load && (pat_sel == SEL_W'(i))) begin
                pat_d[i] = pat_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= PAT_INIT;
        end else begin
            pat_q <= pat_d;
        end
    end

    always_comb begin
        m = '0;
        for (int i = 0; i < NPAT; i++) begin
            m[i] = full && (nh == pat_q[i]);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Serial pattern detector: history shifter, validity fill counter,
// registered match pulses and a saturating match counter.
module seq_detect_prog
    import seq_det_pkg::*;
#(
    parameter int LEN   = SEQ_LEN,
    parameter int NPAT  = SEQ_NPAT,
    parameter int CNT_W = SEQ_CNT_W,
    parameter logic [NPAT*LEN-1:0] PAT_INIT = (NPAT*LEN)'(SEQ_PAT_INIT),
    localparam int SEL_W = (NPAT > 1) ? $clog2(NPAT) : 1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             en,
    input  logic             w,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [SEL_W-1:0] pat_sel,
    input  logic [LEN-1:0]   pat_data,
    input  logic             cnt_clr,
    output logic [NPAT-1:0]  z,
    output logic             z_any,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = $clog2(LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(LEN);

    logic [LEN-1:0]   hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [NPAT-1:0]  z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [LEN-1:0]  nh;
    logic [FW-1:0]   nf;
    logic            full;
    logic [NPAT-1:0] m;
    logic            hit;
    seq_mode_t       mode;

    assign mode = seq_mode_t'(overlap);
    assign nh   = {hist_q[LEN-2:0], w};
    assign nf   = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    assign full = en && (nf == FULL);
    assign hit  = |m;

    seq_pattern_bank #(
        .LEN      (LEN),
        .NPAT     (NPAT),
        .SEL_W    (SEL_W),
        .PAT_INIT (PAT_INIT)
    ) u_bank (
        .clk      (Clock),
        .rst_n    (Resetn),
        .pat_load (pat_load),
        .pat_sel  (pat_sel),
        .pat_data (pat_data),
        .nh       (nh),
        .full     (full),
        .m        (m)
    );

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = '0;
        cnt_d  = cnt_q;
        if (en) begin
            hist_d = nh;
            z_d    = m;
            // Non-overlapping: invalidate history so LEN fresh samples are needed.
            fill_d = (mode == SEQ_NONOVL && hit) ? '0 : nf;
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
        end
    end

    assign z         = z_q;
    assign z_any     = |z_q;
    assign match_cnt = cnt_q;

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Parametrised serial pattern detector. It samples a 1-bit stream `w` and compares the last LEN samples against NPAT runtime-programmable patterns, in overlapping or non-overlapping mode. Outputs are a registered per-pattern match pulse and a saturating match counter. It is the general replacement for the fixed-pattern Moore detectors in the serial front end; its reset patterns reproduce the fixed 1001/1111 detector.

## Interface
- LEN, default 4: pattern length in bits, legal range 2..16.
- NPAT, default 2: number of independent patterns, legal range 1..8.
- CNT_W, default 8: match counter width.
- PAT_INIT, default {4'b1111, 4'b1001}: NPAT*LEN bits giving the reset patterns. Pattern i is slice [i*LEN +: LEN]. Bit LEN-1 of a slice is the first-received bit.
- Clock  in  1  sole clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- en  in  1  sample-enable; `w` is consumed only on edges where en=1.
- w  in  1  serial data bit.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  in  1  write pat_data into pattern pat_sel.
- pat_sel  in  max(1,$clog2(NPAT))  pattern index; values >= NPAT are ignored.
- pat_data  in  LEN  new pattern, same bit order as PAT_INIT.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  NPAT  registered per-pattern match pulse.
- z_any  out  1  OR of z.
- match_cnt  out  CNT_W  saturating count of match events.

## Operation
- State held: hist[LEN-1:0] (newest sample in bit 0), fill (0..LEN, count of valid history bits), pat[NPAT], z, match_cnt.
- On an edge with en=1:
  - nh = {hist[LEN-2:0], w}
  - nf = min(fill+1, LEN)
  - m[i] = (nf==LEN) && (nh==pat[i])
  - hist <= nh
  - z <= m
- fill update:
  - overlap=1: fill <= nf.
  - overlap=0 and any m[i]: fill <= 0. The history bits remain but are invalid, so a fresh LEN samples are needed before the next match.
- On an edge with en=0: hist and fill hold; z <= 0.
- match_cnt:
  - cnt_clr=1: match_cnt <= 0. Clear wins over a same-edge match.
  - Otherwise, on any m[i]: increment by exactly 1, even when several patterns match. Saturate at 2^CNT_W-1 with no wrap.
- Pattern load: pat_load=1 writes pat[pat_sel] <= pat_data at the edge.
  - The comparison on that same edge uses the old pattern.
  - History and fill are not disturbed.
  - pat_sel >= NPAT: no effect.
- overlap may change on any edge. The value sampled on an edge governs that edge's fill update only.
- Reset (Resetn=0, any time, including mid-sequence):
  - hist=0, fill=0, z=0, match_cnt=0, pat[i]=PAT_INIT slice i.
  - Output reset values: z=0, z_any=0, match_cnt=0.
  - The first sample after reset release is a first-received bit; no partial history carries across reset.

## Timing
- Latency: z asserts in the cycle following the rising edge that sampled the final pattern bit. It lasts exactly one cycle unless the next sampled bit completes another match.
- z_any is combinational from z, so it has the same timing.
- match_cnt updates on the same edge as z.
- No handshake backpressure: every en=1 edge consumes one bit.
- Minimum spacing between matches: 1 sample when overlapping, LEN samples when non-overlapping.

## Structure
- Package `seq_det_pkg` holds:
  - default LEN/NPAT/CNT_W constants;
  - default PAT_INIT;
  - a `seq_mode_t` enum {SEQ_NONOVL=1'b0, SEQ_OVL=1'b1} used for the overlap input.
- Sub-module `seq_pattern_bank`: the NPAT pattern registers, load decode, and NPAT comparators. Inputs: nh and the nf==LEN qualifier. Output: m[NPAT-1:0].
- Top level holds the history/fill shifter, z register and counter.

## Test plan
- Reset defaults, overlap=1, en=1, w=1,0,0,1,0,0,1 -> z[0] pulses after samples 4 and 7; z[1] never; match_cnt=2.
- Same stream with overlap=0 -> z[0] pulses after sample 4 only; match_cnt=1. Seven consecutive 1s: overlap=1 gives z[1] after samples 4,5,6,7 (cnt=4); overlap=0 gives sample 4 only (cnt=1).
- Load pat_sel=1, pat_data=4'b1001, then send 1001 -> z=2'b11, z_any=1, match_cnt increments by 1 only.
- Pattern load on the same edge as the completing sample -> the match is judged against the old pattern; the new pattern applies from the next sample. en toggling mid-pattern: bits with en=0 are skipped, and 1,(en=0),0,0,1 still matches.
- CNT_W=2, five overlapping matches -> match_cnt sticks at 3. cnt_clr coincident with a match -> match_cnt=0 while z still pulses.
- Assert Resetn=0 after 3 bits of 1001, release, then send 1 -> no match. The full 1001 then matches; patterns are restored to PAT_INIT after a prior load.
